dac_frame_sequencer: RTL and testbench

Generates the per-channel slot timing (main_state, channel, sample clock) that drives the scalable-HPF DAC output blocks. It also fetches one 16-bit amplifier sample per slot from an upstream sample source through a req/ack handshake and presents it on DAC_input. Sits between the sample buffer and the DAC output blocks, replacing ad-hoc state stepping with a single frame scheduler that supports start/stop and underrun reporting.

---
 rtl/dac_frame_sequencer.sv | 155 +++++++++++++++
 tb/tb_dac_frame_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_frame_sequencer.sv
// DAC frame scheduler: steps slot phase/channel, fetches one sample per slot
// over req/ack, counts frames and reports missed sample deadlines.
module dac_frame_sequencer #(
    parameter int NUM_CHANNELS = 20,
    parameter int SLOT_LEN     = 140,
    parameter int ACK_DEADLINE = 34
) (
    input  logic        dataclk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] max_frames,
    input  logic        underrun_clear,
    input  logic        sample_ack,
    input  logic [15:0] sample_data,
    output logic [31:0] main_state,
    output logic [5:0]  channel,
    output logic        sample_clk,
    output logic        sample_req,
    output logic [15:0] DAC_input,
    output logic        running,
    output logic        done,
    output logic [31:0] frame_count,
    output logic        underrun,
    output logic [15:0] underrun_count
);

    localparam int PW = $clog2(SLOT_LEN);
    localparam int CLK_HIGH = SLOT_LEN / 2;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nx;
    logic [5:0]    chan_nx;
    logic [31:0]   fcount_nx;
    logic          req_nx;
    logic          done_nx;
    logic          sclk_nx;
    logic          slot_end;
    logic          frame_end;
    logic          stop;
    logic          ack_ok;
    logic          miss;

    assign running    = (state == RUN);
    assign main_state = running ? 32'd100 + 32'(phase) : 32'd99;

    assign slot_end  = running && (phase == PW'(SLOT_LEN - 1));
    assign frame_end = slot_end && (channel == 6'(NUM_CHANNELS - 1));
    assign stop      = !run ||
                       ((max_frames != 32'd0) &&
                        (frame_count + 32'd1 == max_frames));

    assign ack_ok = sample_req && sample_ack;
    assign miss   = running && sample_req && !sample_ack &&
                    (phase == PW'(ACK_DEADLINE));

    always_comb begin
        state_nx  = state;
        phase_nx  = phase;
        chan_nx   = channel;
        fcount_nx = frame_count;
        req_nx    = sample_req;
        done_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                req_nx = 1'b0;
                if (run) begin
                    state_nx  = RUN;
                    phase_nx  = '0;
                    chan_nx   = '0;
                    fcount_nx = '0;
                    req_nx    = 1'b1;
                end
            end
            RUN: begin
                phase_nx = phase + PW'(1);
                if (ack_ok || miss) begin
                    req_nx = 1'b0;
                end
                if (slot_end) begin
                    phase_nx = '0;
                    req_nx   = 1'b1;
                    if (!frame_end) begin
                        chan_nx = channel + 6'd1;
                    end else begin
                        fcount_nx = frame_count + 32'd1;
                        chan_nx   = '0;
                        if (stop) begin
                            state_nx = IDLE;
                            done_nx  = 1'b1;
                            req_nx   = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    // Registered from next-state values so it lines up with main_state.
    assign sclk_nx = (state_nx == RUN) && (chan_nx == 6'd0) &&
                     (phase_nx < PW'(CLK_HIGH));

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            phase       <= '0;
            channel     <= '0;
            frame_count <= '0;
            sample_req  <= 1'b0;
            sample_clk  <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            channel     <= chan_nx;
            frame_count <= fcount_nx;
            sample_req  <= req_nx;
            sample_clk  <= sclk_nx;
            done        <= done_nx;
        end
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            DAC_input <= '0;
        end else if (ack_ok) begin
            DAC_input <= sample_data;
        end
    end

    // A deadline miss on the clear edge still registers as one event.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else if (miss) begin
            underrun <= 1'b1;
            if (underrun_clear) begin
                underrun_count <= 16'd1;
            end else if (underrun_count != 16'hFFFF) begin
                underrun_count <= underrun_count + 16'd1;
            end
        end else if (underrun_clear) begin
            underrun       <= 1'b0;
            underrun_count <= '0;
        end
    end

endmodule

// File: tb/tb_dac_frame_sequencer.sv
// Self-checking bench for dac_frame_sequencer: table of run scenarios
// against a slot-level model, plus hand sequences for clear and reset.
module tb_dac_frame_sequencer;

    localparam int NC    = 20;
    localparam int SL    = 140;
    localparam int DL    = 34;
    localparam int FRAME = NC * SL;

    logic        dataclk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic [31:0] max_frames = '0;
    logic        underrun_clear = 1'b0;
    logic        sample_ack = 1'b0;
    logic [15:0] sample_data = '0;
    logic [31:0] main_state;
    logic [5:0]  channel;
    logic        sample_clk;
    logic        sample_req;
    logic [15:0] DAC_input;
    logic        running;
    logic        done;
    logic [31:0] frame_count;
    logic        underrun;
    logic [15:0] underrun_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_dac = '0;
    bit          exp_ur = 1'b0;
    int          exp_cnt = 0;

    typedef struct {
        int mf;
        int drop_t;
        int mode;
        int nfr;
    } vec_t;

    vec_t vecs [6];

    dac_frame_sequencer dut (
        .dataclk(dataclk),
        .reset(reset),
        .run(run),
        .max_frames(max_frames),
        .underrun_clear(underrun_clear),
        .sample_ack(sample_ack),
        .sample_data(sample_data),
        .main_state(main_state),
        .channel(channel),
        .sample_clk(sample_clk),
        .sample_req(sample_req),
        .DAC_input(DAC_input),
        .running(running),
        .done(done),
        .frame_count(frame_count),
        .underrun(underrun),
        .underrun_count(underrun_count)
    );

    always #5 dataclk = ~dataclk;

    task automatic chk(input string name, input longint act,
                       input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d @%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge dataclk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input int exp_done,
                            input int exp_fc);
        chk({tag, " main_state"}, main_state, 99);
        chk({tag, " running"}, running, 0);
        chk({tag, " done"}, done, exp_done);
        chk({tag, " sample_req"}, sample_req, 0);
        chk({tag, " sample_clk"}, sample_clk, 0);
        chk({tag, " frame_count"}, frame_count, exp_fc);
        chk({tag, " DAC_input"}, DAC_input, exp_dac);
    endtask

    // mode 0: ack at phase 1; mode 1: ack at deadline, channel 5 never;
    // mode 2: random ack phase in 0..45 (above the deadline = missed)
    function automatic int plan_ack(input int mode, input int ch);
        if (mode == 0) return 1;
        if (mode == 1) return (ch == 5) ? 999 : DL;
        return int'($urandom_range(0, 45));
    endfunction

    task automatic run_seq(input int mf, input int drop_t,
                           input int mode, input int nfr);
        int a;
        int ph;
        int ch;
        int lim;
        int last;
        logic [15:0] d;
        bit acc;
        bit miss;
        bit clr;
        a = 0;
        d = '0;
        last = nfr * FRAME;
        lim = (drop_t < 0) ? last - 1 : drop_t;
        max_frames = 32'(mf);
        run = 1'b1;
        step();
        for (int t = 0; t < last; t++) begin
            ph = t % SL;
            ch = (t / SL) % NC;
            if (ph == 0) begin
                a = plan_ack(mode, ch);
                d = (mode < 2) ? 16'(ch * 100) : 16'($urandom);
            end
            chk("main_state", main_state, 100 + ph);
            chk("channel", channel, ch);
            chk("sample_clk", sample_clk, (ch == 0 && ph < 70) ? 1 : 0);
            chk("sample_req", sample_req, (ph <= ((a < DL) ? a : DL)) ? 1 : 0);
            chk("DAC_input", DAC_input, exp_dac);
            chk("running", running, 1);
            chk("done", done, 0);
            chk("frame_count", frame_count, t / FRAME);
            chk("underrun", underrun, exp_ur);
            chk("underrun_count", underrun_count, exp_cnt);
            acc = (ph == a) && (a <= DL);
            miss = (ph == DL) && (a > DL);
            clr = (mode == 2) && ($urandom_range(0, 299) == 0);
            sample_ack = (ph == a) ||
                         ((ph > ((a < DL) ? a : DL)) && ($urandom_range(0, 7) == 0));
            sample_data = (ph == a) ? d : 16'($urandom);
            underrun_clear = clr;
            if (t == lim) run = 1'b0;
            step();
            if (acc) exp_dac = d;
            if (miss) begin
                exp_ur = 1'b1;
                exp_cnt = clr ? 1 : ((exp_cnt < 65535) ? exp_cnt + 1 : exp_cnt);
            end else if (clr) begin
                exp_ur = 1'b0;
                exp_cnt = 0;
            end
        end
        sample_ack = 1'b0;
        underrun_clear = 1'b0;
        run = 1'b0;
        chk_idle("end", 1, nfr);
        chk("end underrun_count", underrun_count, exp_cnt);
        step();
        chk_idle("after_done", 0, nfr);
    endtask

    initial begin
        int ph;
        int ch;
        vecs[0] = '{mf: 1, drop_t: -1, mode: 0, nfr: 1};
        vecs[1] = '{mf: 1, drop_t: -1, mode: 1, nfr: 1};
        vecs[2] = '{mf: 0, drop_t: 2 * FRAME + 7 * SL + 13, mode: 2, nfr: 3};
        vecs[3] = '{mf: 2, drop_t: -1, mode: 2, nfr: 2};
        vecs[4] = '{mf: 3, drop_t: FRAME - 1, mode: 2, nfr: 1};
        vecs[5] = '{mf: 0, drop_t: 0, mode: 2, nfr: 1};

        #3;
        chk_idle("reset", 0, 0);
        chk("reset channel", channel, 0);
        chk("reset underrun", underrun, 0);
        chk("reset underrun_count", underrun_count, 0);
        step();
        step();
        reset = 1'b1;
        step();
        chk_idle("idle", 0, 0);

        for (int i = 0; i < 6; i++) begin
            run_seq(vecs[i].mf, vecs[i].drop_t, vecs[i].mode, vecs[i].nfr);
        end

        // clear coinciding with a deadline miss at count 5, then plain clear
        reset = 1'b0;
        #2;
        reset = 1'b1;
        exp_dac = '0;
        chk("rst2 underrun_count", underrun_count, 0);
        max_frames = 32'd1;
        run = 1'b1;
        step();
        for (int t = 0; t < FRAME; t++) begin
            ph = t % SL;
            ch = t / SL;
            if (ch == 5 && ph == DL) begin
                chk("pre_clear underrun_count", underrun_count, 5);
                chk("pre_clear underrun", underrun, 1);
            end
            if (ch == 5 && ph == DL + 1) begin
                chk("clear_vs_set underrun", underrun, 1);
                chk("clear_vs_set underrun_count", underrun_count, 1);
            end
            if (ch == 5 && ph == 61) begin
                chk("clear underrun", underrun, 0);
                chk("clear underrun_count", underrun_count, 0);
            end
            if (ch == 6 && ph == DL + 1) begin
                chk("after_clear underrun_count", underrun_count, 1);
            end
            underrun_clear = (ch == 5) && (ph == DL || ph == 60);
            if (t == FRAME - 1) run = 1'b0;
            step();
        end
        underrun_clear = 1'b0;
        chk_idle("clr_end", 1, 1);
        chk("clr_end underrun_count", underrun_count, 14);

        // asynchronous reset mid-slot
        max_frames = 32'd0;
        run = 1'b1;
        step();
        for (int t = 0; t < 3 * SL + 50; t++) begin
            ph = t % SL;
            sample_ack = (ph == 1);
            sample_data = 16'hBE00 + 16'(t / SL);
            step();
        end
        sample_ack = 1'b0;
        chk("pre_reset channel", channel, 3);
        chk("pre_reset main_state", main_state, 150);
        chk("pre_reset DAC_input", DAC_input, 16'hBE03);
        #2;
        reset = 1'b0;
        #1;
        exp_dac = '0;
        chk_idle("async_reset", 0, 0);
        chk("async_reset channel", channel, 0);
        chk("async_reset underrun", underrun, 0);
        chk("async_reset underrun_count", underrun_count, 0);
        step();
        chk_idle("held_reset", 0, 0);
        #2;
        reset = 1'b1;
        step();
        chk("restart main_state", main_state, 100);
        chk("restart channel", channel, 0);
        chk("restart running", running, 1);
        chk("restart sample_req", sample_req, 1);
        chk("restart sample_clk", sample_clk, 1);
        chk("restart frame_count", frame_count, 0);
        step();
        chk("restart main_state+1", main_state, 101);
        run = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk_idle("final", 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
